mem_fill_responder: RTL and testbench

Memory-side responder for cache block fills and word stores. It sits behind the cache fill FSM: it accepts one block fill request, waits a fixed access latency, then streams the 8 words of the block one per cycle with a valid strobe. It also services single-word writes (SW write-through) into its backing array. It is the main-memory model used by both the I-cache and the D-cache.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_fill_responder_if.sv | 37 +++
 rtl/mem_fill_responder_fill_memory_array.sv | 34 +++
 rtl/mem_fill_responder.sv | 171 +++++++++++++++++
 tb/tb_mem_fill_responder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory fill responder.
// Block geometry (8 words per block, 3-bit word offset), FSM state encoding
// and the default bus widths/latency used by the responder and its interface.
// Build option: CRITICAL_WORD_FIRST_EN (consumed by mem_fill_responder).
package mem_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_W    = 3;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_MEM_AW  = 12;
    localparam int DEF_LATENCY = 4;

    // Wide enough for the largest legal LATENCY (15).
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

endpackage : mem_pkg

// File: rtl/mem_fill_responder_if.sv
// mem_fill_responder_if: fill/write/response bundle between a cache fill FSM
// (master) and the memory responder (slave).
//   req_valid/req_addr/req_ready          block fill request handshake
//   wr_en/wr_addr/wr_data/wr_ready        single-word write handshake
//   resp_valid/resp_addr/resp_data/resp_last  returned burst words
interface mem_fill_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              resp_valid;
    logic [ADDR_W-1:0] resp_addr;
    logic [DATA_W-1:0] resp_data;
    logic              resp_last;

    modport master (
        output req_valid, req_addr, wr_en, wr_addr, wr_data,
        input  req_ready, wr_ready, resp_valid, resp_addr, resp_data, resp_last
    );

    modport slave (
        input  req_valid, req_addr, wr_en, wr_addr, wr_data,
        output req_ready, wr_ready, resp_valid, resp_addr, resp_data, resp_last
    );

endinterface : mem_fill_responder_if

// File: rtl/mem_fill_responder_fill_memory_array.sv
// fill_memory_array: 2^MEM_AW x DATA_W backing store for the fill responder.
// One synchronous write port, one asynchronous read port; contents are not
// reset.
//   clk    clock (write on rising edge)
//   we     write enable
//   waddr  write index
//   wdata  write data
//   raddr  read index
//   rdata  read data (combinational)
module fill_memory_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MEM_AW = DEF_MEM_AW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [MEM_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [MEM_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**MEM_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fill_memory_array

// File: rtl/mem_fill_responder.sv
// mem_fill_responder: main-memory model behind the I/D-cache fill FSMs.
// Accepts one block fill in IDLE, waits LATENCY cycles from accept to the
// first word, then streams the 8 words of the block one per cycle with
// resp_last on the 8th. Single-word writes are taken only in IDLE; a write
// accepted together with a fill is visible to that fill (write-first).
// Build option: CRITICAL_WORD_FIRST_EN -- burst starts at req_addr[2:0] and
// wraps modulo 8; otherwise the burst always starts at word 0.
//   clk  clock, all state on rising edge
//   rst  asynchronous active-low reset
//   bus  slave side of mem_fill_responder_if (request, write, response)
module mem_fill_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_AW  = DEF_MEM_AW,
    parameter int LATENCY = DEF_LATENCY
) (
    input logic                 clk,
    input logic                 rst,
    mem_fill_responder_if.slave bus
);

    localparam int                  BASE_W    = ADDR_W - OFFSET_W;
    localparam logic [LAT_W-1:0]    LAT_M1    = LAT_W'(LATENCY - 1);
    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(BLOCK_WORDS - 1);

    state_t              state_q;
    logic [BASE_W-1:0]   base_q;
    logic [OFFSET_W-1:0] start_q;
    logic [OFFSET_W-1:0] idx_q;
    logic [OFFSET_W-1:0] beat_q;
    logic [LAT_W-1:0]    cnt_q;

    logic                resp_valid_q;
    logic                resp_last_q;
    logic [ADDR_W-1:0]   resp_addr_q;
    logic [DATA_W-1:0]   resp_data_q;

    logic                idle;
    logic                req_fire;
    logic                wr_fire;
    logic [OFFSET_W-1:0] req_off;
    logic [OFFSET_W-1:0] idx_nxt;
    logic [ADDR_W-1:0]   rd_addr;
    logic [MEM_AW-1:0]   rd_index;
    logic [DATA_W-1:0]   arr_data;
    logic [DATA_W-1:0]   rd_data;
    logic                unused_bits;

    assign idle     = (state_q == IDLE);
    assign req_fire = bus.req_valid & idle;
    assign wr_fire  = bus.wr_en & idle;
    assign idx_nxt  = idx_q + OFFSET_W'(1);

`ifdef CRITICAL_WORD_FIRST_EN
    assign req_off     = bus.req_addr[OFFSET_W-1:0];
    assign unused_bits = ^{bus.wr_addr[ADDR_W-1:MEM_AW], rd_addr[ADDR_W-1:MEM_AW]};
`else
    assign req_off     = '0;
    assign unused_bits = ^{bus.wr_addr[ADDR_W-1:MEM_AW], rd_addr[ADDR_W-1:MEM_AW],
                           bus.req_addr[OFFSET_W-1:0]};
`endif

    // Address of the word loaded into the response registers at the coming
    // edge: the first word on burst entry, the next wrapped word in BURST.
    always_comb begin
        rd_addr = {base_q, idx_nxt};
        case (state_q)
            IDLE:    rd_addr = {bus.req_addr[ADDR_W-1:OFFSET_W], req_off};
            WAIT:    rd_addr = {base_q, start_q};
            default: rd_addr = {base_q, idx_nxt};
        endcase
    end

    assign rd_index = rd_addr[MEM_AW-1:0];

    // With LATENCY==1 the first word is loaded on the accept edge, the same
    // edge a simultaneous write commits; forward the write data so the burst
    // sees the new value.
    assign rd_data = (wr_fire && (bus.wr_addr[MEM_AW-1:0] == rd_index)) ? bus.wr_data : arr_data;

    fill_memory_array #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_array (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (bus.wr_addr[MEM_AW-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_index),
        .rdata (arr_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            start_q      <= '0;
            idx_q        <= '0;
            beat_q       <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_addr_q  <= '0;
            resp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    resp_last_q  <= 1'b0;
                    if (req_fire) begin
                        base_q  <= bus.req_addr[ADDR_W-1:OFFSET_W];
                        start_q <= req_off;
                        if (LATENCY == 1) begin
                            state_q      <= BURST;
                            idx_q        <= req_off;
                            beat_q       <= '0;
                            resp_valid_q <= 1'b1;
                            resp_addr_q  <= rd_addr;
                            resp_data_q  <= rd_data;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == LAT_W'(1)) begin
                        state_q      <= BURST;
                        cnt_q        <= '0;
                        idx_q        <= start_q;
                        beat_q       <= '0;
                        resp_valid_q <= 1'b1;
                        resp_last_q  <= 1'b0;
                        resp_addr_q  <= rd_addr;
                        resp_data_q  <= rd_data;
                    end else begin
                        cnt_q <= cnt_q - LAT_W'(1);
                    end
                end
                BURST: begin
                    if (beat_q == LAST_BEAT) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_last_q  <= 1'b0;
                    end else begin
                        beat_q      <= beat_q + OFFSET_W'(1);
                        idx_q       <= idx_nxt;
                        resp_addr_q <= rd_addr;
                        resp_data_q <= rd_data;
                        resp_last_q <= (beat_q == LAST_BEAT - OFFSET_W'(1));
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = idle;
    assign bus.wr_ready   = idle;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_last  = resp_last_q;
    assign bus.resp_addr  = resp_addr_q;
    assign bus.resp_data  = resp_data_q;

endmodule : mem_fill_responder

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: self-checking bench for mem_fill_responder.
// Two instances: LATENCY=4 (main) and LATENCY=1. Expected bursts come from a
// word-array model of memory and the block/offset rules; honours
// CRITICAL_WORD_FIRST_EN when defined.
module tb_mem_fill_responder;

    localparam int LAT = 4;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk;
    logic rst;

    mem_fill_responder_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
    mem_fill_responder_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

    mem_fill_responder #(.ADDR_W(16), .DATA_W(16), .MEM_AW(12), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    mem_fill_responder #(.ADDR_W(16), .DATA_W(16), .MEM_AW(12), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] model_mem [4096];

    typedef struct {
        logic [15:0] addr;
        bit          wr;
        logic [15:0] wa;
        logic [15:0] wd;
        bit          hold;
        logic [15:0] exp_first;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    // Expected burst: block base, starting word per build, wrap modulo 8,
    // data taken from the model after any same-cycle write.
    task automatic expect_burst(input logic [15:0] a, output logic [15:0] ea [8],
                                output logic [15:0] ed [8]);
        logic [15:0] base;
        int          st;
        base = {a[15:3], 3'b000};
        st   = CWF ? int'(a[2:0]) : 0;
        for (int k = 0; k < 8; k++) begin
            ea[k] = base + 16'((st + k) % 8);
            ed[k] = model_mem[ea[k][11:0]];
        end
    endtask

    // Fill on the main instance starting in IDLE at cycle 0. wr: write in the
    // accept cycle. hold: write requested from cycle 1 and held until taken.
    task automatic run_fill(input logic [15:0] a, input bit wr, input logic [15:0] wa,
                            input logic [15:0] wd, input bit hold, output logic [15:0] first_a);
        logic [15:0] ea [8];
        logic [15:0] ed [8];
        bit          in_b;
        int          k;
        first_a = '1;
        check1("pre_req_ready", bus0.req_ready, 1'b1);
        if (wr) model_mem[wa[11:0]] = wd;
        expect_burst(a, ea, ed);
        bus0.req_valid = 1'b1;
        bus0.req_addr  = a;
        bus0.wr_en     = wr;
        bus0.wr_addr   = wa;
        bus0.wr_data   = wd;
        tick();
        bus0.req_valid = 1'b0;
        bus0.wr_en     = hold;
        for (int c = 1; c <= LAT + 8; c++) begin
            in_b = (c >= LAT) && (c <= LAT + 7);
            k    = c - LAT;
            check1("resp_valid", bus0.resp_valid, in_b);
            if (in_b) begin
                check16("resp_addr", bus0.resp_addr, ea[k]);
                check16("resp_data", bus0.resp_data, ed[k]);
                check1("resp_last", bus0.resp_last, k == 7);
                if (k == 0) first_a = bus0.resp_addr;
            end else begin
                check1("resp_last_idle", bus0.resp_last, 1'b0);
            end
            check1("req_ready", bus0.req_ready, c == LAT + 8);
            check1("wr_ready", bus0.wr_ready, c == LAT + 8);
            if (c < LAT + 8) tick();
        end
        if (hold) begin
            tick();
            model_mem[wa[11:0]] = wd;
            bus0.wr_en = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [15:0] first;
        logic [15:0] ea [8];
        logic [15:0] ed [8];
        logic [15:0] d;
        logic [15:0] a;
        logic [15:0] wa;
        bit          wr;
        bit          hold;

        vecs[0] = '{16'h0100, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0100};
        vecs[1] = '{16'h0106, 1'b0, 16'h0000, 16'h0000, 1'b0, CWF ? 16'h0106 : 16'h0100};
        vecs[2] = '{16'h0100, 1'b1, 16'h0102, 16'hBEEF, 1'b0, 16'h0100};
        vecs[3] = '{16'h0100, 1'b0, 16'h0104, 16'h7777, 1'b1, 16'h0100};
        vecs[4] = '{16'h0103, 1'b0, 16'h0000, 16'h0000, 1'b0, CWF ? 16'h0103 : 16'h0100};
        vecs[5] = '{16'hF9FA, 1'b0, 16'h0000, 16'h0000, 1'b0, CWF ? 16'hF9FA : 16'hF9F8};
        vecs[6] = '{16'h0127, 1'b1, 16'h0125, 16'h5555, 1'b0, CWF ? 16'h0127 : 16'h0120};

        rst = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.wr_en = 1'b0;
        bus0.wr_addr = '0; bus0.wr_data = '0;
        bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.wr_en = 1'b0;
        bus1.wr_addr = '0; bus1.wr_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check1("rst_req_ready", bus0.req_ready, 1'b1);
        check1("rst_wr_ready", bus0.wr_ready, 1'b1);
        check1("rst_resp_valid", bus0.resp_valid, 1'b0);
        check1("rst_resp_last", bus0.resp_last, 1'b0);
        check16("rst_resp_addr", bus0.resp_addr, 16'h0000);
        check16("rst_resp_data", bus0.resp_data, 16'h0000);
        check1("rst_l1_resp_valid", bus1.resp_valid, 1'b0);
        rst = 1'b1;
        tick();

        // Preload both arrays identically; block 0x0100 gets 0xA000..0xA007.
        for (int i = 0; i < 4096; i++) begin
            d = (i >= 256 && i < 264) ? 16'hA000 + 16'(i - 256) : 16'($urandom);
            model_mem[i] = d;
            bus0.wr_en = 1'b1; bus0.wr_addr = 16'(i); bus0.wr_data = d;
            bus1.wr_en = 1'b1; bus1.wr_addr = 16'(i); bus1.wr_data = d;
            tick();
        end
        bus0.wr_en = 1'b0;
        bus1.wr_en = 1'b0;

        // LATENCY=1 with a same-cycle write to the first burst word.
        check1("l1_pre_ready", bus1.req_ready, 1'b1);
        wa = CWF ? 16'h0305 : 16'h0300;
        model_mem[wa[11:0]] = 16'h1357;
        expect_burst(16'h0305, ea, ed);
        bus1.req_valid = 1'b1; bus1.req_addr = 16'h0305;
        bus1.wr_en = 1'b1; bus1.wr_addr = wa; bus1.wr_data = 16'h1357;
        bus0.wr_en = 1'b1; bus0.wr_addr = wa; bus0.wr_data = 16'h1357;
        tick();
        bus1.req_valid = 1'b0; bus1.wr_en = 1'b0; bus0.wr_en = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            check1("l1_resp_valid", bus1.resp_valid, c <= 8);
            if (c <= 8) begin
                check16("l1_resp_addr", bus1.resp_addr, ea[c-1]);
                check16("l1_resp_data", bus1.resp_data, ed[c-1]);
                check1("l1_resp_last", bus1.resp_last, c == 8);
            end
            check1("l1_req_ready", bus1.req_ready, c == 9);
            if (c < 9) tick();
        end
        check16("l1_first_word_new", ed[0], 16'h1357);

        // Directed vector table on the main instance.
        for (int i = 0; i < 7; i++) begin
            run_fill(vecs[i].addr, vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].hold, first);
            check16("vec_first_addr", first, vecs[i].exp_first);
        end
        check16("model_beef", model_mem[12'h102], 16'hBEEF);

        // Reset during BURST at word 3.
        bus0.req_valid = 1'b1; bus0.req_addr = 16'h0100;
        tick();
        bus0.req_valid = 1'b0;
        repeat (LAT + 2) tick();
        check1("mid_valid", bus0.resp_valid, 1'b1);
        check16("mid_addr", bus0.resp_addr, 16'h0103);
        #2 rst = 1'b0;
        #1;
        check1("arst_resp_valid", bus0.resp_valid, 1'b0);
        check1("arst_resp_last", bus0.resp_last, 1'b0);
        check1("arst_req_ready", bus0.req_ready, 1'b1);
        check1("arst_wr_ready", bus0.wr_ready, 1'b1);
        check16("arst_resp_addr", bus0.resp_addr, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < LAT + 8; c++) begin
            check1("post_rst_quiet", bus0.resp_valid, 1'b0);
            tick();
        end
        run_fill(16'h0100, 1'b0, 16'h0000, 16'h0000, 1'b0, first);

        // Randomized back-to-back fills with optional writes.
        for (int i = 0; i < 40; i++) begin
            a    = 16'($urandom);
            wr   = 1'($urandom_range(0, 1));
            wa   = ($urandom_range(0, 1) == 1) ? {a[15:3], 3'($urandom)} : 16'($urandom);
            d    = 16'($urandom);
            hold = !wr && ($urandom_range(0, 3) == 0);
            run_fill(a, wr, wa, d, hold, first);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_fill_responder
